// File: rtl/return_addr_stack.sv
// ---------------------------------------------------------------------------
// return_addr_stack
//
// Return address stack for the fetch stage. A BL in fetch pushes its return
// address (PC+4, the value written to X30); a BR X30 in fetch pops the top.
// The top entry is presented combinationally as the predicted return target.
// Storage is a circular buffer of DEPTH 64-bit entries addressed by a
// top-of-stack pointer, so a push onto a full stack silently overwrites the
// oldest entry.
//
// Parameters
//   DEPTH       number of entries (power of two, >= 2)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous active-high reset (clears entries, tos, count)
//   push        push push_addr this cycle
//   push_addr   64-bit return address to save
//   pop         consume the top entry this cycle
//   flush       empty the stack (overrides push/pop)
//   pred_valid  top entry holds a valid prediction (count != 0)
//   pred_addr   predicted return target, entry[tos] or 0 when empty
//   count       number of valid entries, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
// ---------------------------------------------------------------------------
module return_addr_stack #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [63:0]              push_addr,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     pred_valid,
    output logic [63:0]              pred_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // Reject illegal stack sizes at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("return_addr_stack: DEPTH must be a power of two and at least 2");
    end

    logic [63:0]      entry_r [DEPTH];
    logic [PTR_W-1:0] tos_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] tos_s;
    logic [CNT_W-1:0] count_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic             nonempty_s;

    assign nonempty_s = (count_r != CNT_ZERO);

    // Next-state decode: flush beats push/pop; reset is applied in the register.
    always_comb begin
        tos_s    = tos_r;
        count_s  = count_r;
        wr_en_s  = 1'b0;
        wr_idx_s = tos_r;
        if (flush) begin
            tos_s   = PTR_ZERO;
            count_s = CNT_ZERO;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // Push: pointer wraps, so a full stack overwrites its oldest slot.
                    tos_s    = tos_r + PTR_ONE;
                    wr_idx_s = tos_r + PTR_ONE;
                    wr_en_s  = 1'b1;
                    if (count_r == CNT_DEPTH) begin
                        count_s = count_r;
                    end else begin
                        count_s = count_r + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (nonempty_s) begin
                        tos_s   = tos_r - PTR_ONE;
                        count_s = count_r - CNT_ONE;
                    end else begin
                        tos_s   = tos_r;
                        count_s = count_r;
                    end
                end
                2'b11: begin
                    if (nonempty_s) begin
                        // Call and return together: replace the top in place.
                        wr_idx_s = tos_r;
                        wr_en_s  = 1'b1;
                    end else begin
                        // Nothing to pop, so this is a plain push.
                        tos_s    = tos_r + PTR_ONE;
                        wr_idx_s = tos_r + PTR_ONE;
                        wr_en_s  = 1'b1;
                        count_s  = count_r + CNT_ONE;
                    end
                end
                default: begin
                    tos_s   = tos_r;
                    count_s = count_r;
                end
            endcase
        end
    end

    // State registers: synchronous reset clears pointer, count and all entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            tos_r   <= PTR_ZERO;
            count_r <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= 64'h0;
            end
        end else begin
            tos_r   <= tos_s;
            count_r <= count_s;
            if (wr_en_s) begin
                entry_r[wr_idx_s] <= push_addr;
            end
        end
    end

    // Output decode: zero-cycle read of the current top and count flags.
    always_comb begin
        pred_valid = nonempty_s;
        full       = (count_r == CNT_DEPTH);
        empty      = (count_r == CNT_ZERO);
        count      = count_r;
        if (nonempty_s) begin
            pred_addr = entry_r[tos_r];
        end else begin
            pred_addr = 64'h0;
        end
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// ---------------------------------------------------------------------------
// tb_return_addr_stack
//
// Self-checking bench for return_addr_stack (DEPTH=8). A reference stack
// model is updated whenever a cycle of stimulus is driven; the expected
// post-edge outputs are queued in a scoreboard and compared against the DUT
// one time-step after the following rising edge. Before each edge the
// current outputs are also compared against the model's pre-edge state to
// confirm inputs (including reset) do not alter outputs combinationally.
// ---------------------------------------------------------------------------
module tb_return_addr_stack;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        push;
    logic [63:0] push_addr;
    logic        pop;
    logic        flush;
    logic        pred_valid;
    logic [63:0] pred_addr;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    return_addr_stack #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_addr  (push_addr),
        .pop        (pop),
        .flush      (flush),
        .pred_valid (pred_valid),
        .pred_addr  (pred_addr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  cnt;
        logic        vld;
        logic [63:0] addr;
        logic        ful;
        logic        emp;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mdl[$];
    bit          mdl_known;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mdl_top();
        if (mdl.size() > 0) return mdl[mdl.size() - 1];
        else return 64'h0;
    endfunction

    // Reference behaviour of one clock edge.
    task automatic mdl_apply(input bit r, input bit pu, input bit po, input bit fl,
                             input logic [63:0] a);
        if (r) begin
            mdl.delete();
        end else if (fl) begin
            mdl.delete();
        end else if (pu && po) begin
            if (mdl.size() > 0) mdl[mdl.size() - 1] = a;
            else mdl.push_back(a);
        end else if (pu) begin
            if (mdl.size() == DEPTH) void'(mdl.pop_front());
            mdl.push_back(a);
        end else if (po) begin
            if (mdl.size() > 0) void'(mdl.pop_back());
        end
    endtask

    task automatic step(input string tag, input bit r, input bit pu, input bit po,
                        input bit fl, input logic [63:0] a);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset     = r;
        push      = pu;
        pop       = po;
        flush     = fl;
        push_addr = a;
        #1;
        if (mdl_known) begin
            check({tag, ".pre_addr"}, pred_addr, mdl_top());
            check({tag, ".pre_cnt"}, 64'(count), 64'(mdl.size()));
        end
        mdl_apply(r, pu, po, fl, a);
        if (r) mdl_known = 1'b1;
        e.tag  = tag;
        e.cnt  = 4'(mdl.size());
        e.vld  = (mdl.size() > 0);
        e.addr = mdl_top();
        e.ful  = (mdl.size() == DEPTH);
        e.emp  = (mdl.size() == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        got = sb.pop_front();
        check({got.tag, ".cnt"},   64'(count),      64'(got.cnt));
        check({got.tag, ".valid"}, 64'(pred_valid), 64'(got.vld));
        check({got.tag, ".addr"},  pred_addr,       got.addr);
        check({got.tag, ".full"},  64'(full),       64'(got.ful));
        check({got.tag, ".empty"}, 64'(empty),      64'(got.emp));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        mdl_known = 1'b0;
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        push_addr = 64'h0;

        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        check("reset.addr_abs", pred_addr, 64'h0);
        check("reset.empty_abs", 64'(empty), 64'h1);

        // Basic push/pop ordering.
        step("p1", 1'b0, 1'b1, 1'b0, 1'b0, 64'h1004);
        step("p2", 1'b0, 1'b1, 1'b0, 1'b0, 64'h2008);
        step("p3", 1'b0, 1'b1, 1'b0, 1'b0, 64'h300C);
        check("p3.addr_abs", pred_addr, 64'h300C);
        step("o1", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        check("o1.addr_abs", pred_addr, 64'h2008);
        step("o2", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        step("o3", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        check("o3.valid_abs", 64'(pred_valid), 64'h0);

        // Overflow: nine pushes into eight entries, then drain.
        for (int i = 1; i <= 9; i++) begin
            step("ovf_push", 1'b0, 1'b1, 1'b0, 1'b0, 64'(i * 256));
        end
        check("ovf.full_abs", 64'(full), 64'h1);
        check("ovf.addr_abs", pred_addr, 64'h900);
        for (int i = 0; i < 8; i++) begin
            step("ovf_pop", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        end
        check("ovf.empty_abs", 64'(empty), 64'h1);

        // Pop on empty after reset, then a push.
        step("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        step("pop_empty", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        step("push40", 1'b0, 1'b1, 1'b0, 1'b0, 64'h40);
        check("push40.addr_abs", pred_addr, 64'h40);

        // Simultaneous push/pop with a non-empty stack replaces the top.
        step("rst3", 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        step("h10", 1'b0, 1'b1, 1'b0, 1'b0, 64'h10);
        step("h20", 1'b0, 1'b1, 1'b0, 1'b0, 64'h20);
        step("repl99", 1'b0, 1'b1, 1'b1, 1'b0, 64'h99);
        check("repl99.cnt_abs", 64'(count), 64'h2);
        step("repl_pop", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        check("repl_pop.addr_abs", pred_addr, 64'h10);

        // Simultaneous push/pop on empty acts as a push.
        step("rst4", 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        step("pp_empty", 1'b0, 1'b1, 1'b1, 1'b0, 64'h77);
        check("pp_empty.addr_abs", pred_addr, 64'h77);

        // Flush and reset both override a push.
        step("f1", 1'b0, 1'b1, 1'b0, 1'b0, 64'hA1);
        step("f2", 1'b0, 1'b1, 1'b0, 1'b0, 64'hA2);
        step("flush_push", 1'b0, 1'b1, 1'b0, 1'b1, 64'h55);
        check("flush_push.empty_abs", 64'(empty), 64'h1);
        step("g1", 1'b0, 1'b1, 1'b0, 1'b0, 64'hB1);
        step("rst_push", 1'b1, 1'b1, 1'b0, 1'b0, 64'hB2);
        check("rst_push.addr_abs", pred_addr, 64'h0);

        // Random mix, including wrap-around, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit fl;
            r  = ($urandom_range(0, 59) == 0);
            fl = ($urandom_range(0, 19) == 0);
            step("rnd", r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), fl,
                 {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of stack entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 push  input  1  BL in fetch; push push_addr (PC+4, the value written to X30).
REQ-005 push_addr  input  64  return address to save.
REQ-006 pop  input  1  BR X30 (return) in fetch; consume top entry.
REQ-007 flush  input  1  pipeline flush; empty the stack.
REQ-008 pred_valid  output  1  top entry holds a valid return prediction.
REQ-009 pred_addr  output  64  predicted return target (top entry).
REQ-010 count  output  log2(DEPTH)+1  number of valid entries.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.

Function
REQ-013 Storage SHALL be DEPTH x 64-bit registers, addressed as a circular buffer by a top-of-stack pointer tos (log2(DEPTH) bits).
REQ-014 pred_addr SHALL be combinational: entry[tos] when count>0, else 64'h0.
REQ-015 pred_valid, full, and empty SHALL be combinational decodes of count.
REQ-016 Operation priority per cycle SHALL be: reset > flush > push/pop.
REQ-017 Push only: tos <= tos+1 mod DEPTH; entry[tos+1] <= push_addr; count <= count+1, saturating at DEPTH.
REQ-018 Push when full SHALL overwrite the oldest entry (wrap-around); count stays DEPTH; no error output.
REQ-019 Pop only, count>0: tos <= tos-1 mod DEPTH; count <= count-1; entry contents unchanged.
REQ-020 Pop when empty SHALL be ignored: tos, count, and entries unchanged.
REQ-021 Push and pop in the same cycle with count>0: entry[tos] <= push_addr; tos and count unchanged (replace top).
REQ-022 Push and pop in the same cycle with count==0: SHALL behave as push only (count becomes 1).
REQ-023 Flush: count <= 0 and tos <= 0; entry contents may be left unchanged; a simultaneous push or pop SHALL be ignored.
REQ-024 Outputs in the cycle of a push/pop SHALL reflect pre-edge state; new top visible the cycle after the edge (zero-cycle read, one-cycle write latency).
REQ-025 Pointer and count arithmetic SHALL wrap modulo DEPTH for tos and never exceed DEPTH or go below 0 for count.

Reset
REQ-026 On reset: all entries <= 64'h0, tos <= 0, count <= 0; hence pred_valid=0, pred_addr=64'h0, empty=1, full=0.
REQ-027 Reset asserted mid-sequence SHALL override any push, pop, or flush in that cycle.
REQ-028 Reset SHALL take effect only on the clock edge; outputs SHALL not change asynchronously.

Verification
REQ-029 Reset, then push 0x1004, 0x2008, 0x300C on consecutive cycles -> count=3, pred_addr=0x300C; pop x3 -> pred_addr 0x2008, 0x1004, then pred_valid=0, pred_addr=0.
REQ-030 DEPTH=8: push 0x100..0x900 (step 0x100, 9 pushes) -> full=1, count=8, pred_addr=0x900; 8 pops return 0x900..0x200; then empty=1 (0x100 lost).
REQ-031 Pop on empty after reset -> count stays 0, pred_valid=0; a following push 0x40 -> count=1, pred_addr=0x40.
REQ-032 Stack holds 0x10, 0x20; assert push=1 (0x99) and pop=1 together -> count=2, pred_addr=0x99; pop -> pred_addr=0x10.
REQ-033 Empty stack; assert push (0x77) and pop together -> count=1, pred_addr=0x77.
REQ-034 Stack holds 3 entries; assert flush with push (0x55) -> count=0, empty=1; assert reset with push in the same cycle -> count=0, pred_addr=0.
